// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - opcode constants, field positions and issue state type shared by issue logic
package decode_pkg;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_MSB = 6;
    localparam int RD_LSB     = 7;
    localparam int RD_MSB     = 11;
    localparam int RS1_LSB    = 15;
    localparam int RS1_MSB    = 19;
    localparam int RS2_LSB    = 20;
    localparam int RS2_MSB    = 24;
    localparam int IMM_LSB    = 20;
    localparam int IMM_MSB    = 31;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_FULL   = 2'd1,
        ST_HAZARD = 2'd2
    } issue_state_t;

    function automatic logic reads_rs1(input logic [6:0] op);
        return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
    endfunction

    function automatic logic reads_rs2(input logic [6:0] op);
        return (op == OP_REG || op == OP_STORE || op == OP_BRANCH);
    endfunction

    function automatic logic writes_rd(input logic [6:0] op);
        return !(op == OP_STORE || op == OP_BRANCH);
    endfunction

endpackage

// File: rtl/busy_scoreboard.sv
// rtl/busy_scoreboard.sv - per-register outstanding-write bits; ISSUE_WB_BYPASS_EN masks same-cycle writebacks on reads
module busy_scoreboard (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       set_en,
    input  logic [4:0] set_rd,
    input  logic       clr_en,
    input  logic [4:0] clr_rd,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic [4:0] rd,
    output logic       rs1_busy,
    output logic       rs2_busy,
    output logic       rd_busy
);

    logic [31:0] busy;
    logic [31:0] set_mask;
    logic [31:0] clr_mask;
    logic [31:0] view;

    // x0 is excluded from both masks, so busy[0] stays zero forever
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en && set_rd != 5'd0) set_mask[set_rd] = 1'b1;
        if (clr_en && clr_rd != 5'd0) clr_mask[clr_rd] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~clr_mask) | set_mask;
        end
    end

`ifdef ISSUE_WB_BYPASS_EN
    assign view = busy & ~clr_mask;
`else
    assign view = busy;
`endif

    assign rs1_busy = view[rs1];
    assign rs2_busy = view[rs2];
    assign rd_busy  = view[rd];

endmodule

// File: rtl/issue_ctrl.sv
// rtl/issue_ctrl.sv - single-entry issue buffer with scoreboard hazard hold and stall counter
module issue_ctrl
    import decode_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   f_valid,
    input  logic [31:0]            f_instr,
    output logic                   f_ready,
    output logic                   i_valid,
    input  logic                   i_ready,
    output logic [31:0]            i_instr,
    output logic [4:0]             i_rs1,
    output logic [4:0]             i_rs2,
    output logic [4:0]             i_rd,
    output logic [6:0]             i_opcode,
    input  logic                   wb_valid,
    input  logic [4:0]             wb_rd,
    input  logic                   flush,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    logic         held;
    logic [31:0]  instr;
    issue_state_t state;
    logic         hazard;
    logic         issue;
    logic         fetch;
    logic         rs1_busy;
    logic         rs2_busy;
    logic         rd_busy;

    assign i_instr  = instr;
    assign i_opcode = instr[OPCODE_MSB:OPCODE_LSB];
    assign i_rd     = instr[RD_MSB:RD_LSB];
    assign i_rs1    = instr[RS1_MSB:RS1_LSB];
    assign i_rs2    = instr[RS2_MSB:RS2_LSB];

    busy_scoreboard u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (issue && writes_rd(i_opcode)),
        .set_rd   (i_rd),
        .clr_en   (wb_valid),
        .clr_rd   (wb_rd),
        .rs1      (i_rs1),
        .rs2      (i_rs2),
        .rd       (i_rd),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy),
        .rd_busy  (rd_busy)
    );

    // busy[0] is never set, so x0 operands cannot raise a hazard
    assign hazard = (reads_rs1(i_opcode) && rs1_busy)
                  | (reads_rs2(i_opcode) && rs2_busy)
                  | (writes_rd(i_opcode) && rd_busy);

    // FULL vs HAZARD is recomputed every cycle from the live scoreboard
    always_comb begin
        state = ST_EMPTY;
        if (held) state = hazard ? ST_HAZARD : ST_FULL;
    end

    assign i_valid = (state == ST_FULL) && !flush;
    assign f_ready = !flush && (state == ST_EMPTY || (i_valid && i_ready));
    assign issue   = i_valid && i_ready;
    assign fetch   = f_valid && f_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held  <= 1'b0;
            instr <= '0;
        end else if (flush) begin
            held  <= 1'b0;
            instr <= '0;
        end else if (fetch) begin
            held  <= 1'b1;
            instr <= f_instr;
        end else if (issue) begin
            held  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (state == ST_HAZARD && stall_cnt != {STALL_CNT_W{1'b1}}) begin
            stall_cnt <= stall_cnt + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_issue_ctrl.sv
// tb/tb_issue_ctrl.sv - directed plus random checks of issue_ctrl against a register-usage reference model
module tb_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        f_valid = 1'b0;
    logic [31:0] f_instr = '0;
    logic        i_ready = 1'b0;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic        flush = 1'b0;
    logic        f_ready;
    logic        i_valid;
    logic [31:0] i_instr;
    logic [4:0]  i_rs1;
    logic [4:0]  i_rs2;
    logic [4:0]  i_rd;
    logic [6:0]  i_opcode;
    logic [15:0] stall_cnt;

    issue_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .f_valid   (f_valid),
        .f_instr   (f_instr),
        .f_ready   (f_ready),
        .i_valid   (i_valid),
        .i_ready   (i_ready),
        .i_instr   (i_instr),
        .i_rs1     (i_rs1),
        .i_rs2     (i_rs2),
        .i_rd      (i_rd),
        .i_opcode  (i_opcode),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .flush     (flush),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] ADDI_X1 = 32'h00500093;
    localparam logic [31:0] ADDI_X2 = 32'h00700113;
    localparam logic [31:0] ADDI_X3 = 32'h00300193;
    localparam logic [31:0] ADD_321 = 32'h002081B3;
    localparam logic [31:0] SW_12   = 32'h00112023;
    localparam logic [31:0] LUI_X0  = 32'h00001037;
    localparam logic [31:0] ADDI_70 = 32'h00000393;
    localparam logic [31:0] ADDI_X5 = 32'h00100293;
    localparam logic [31:0] ADDI_65 = 32'h00028313;

    int checks = 0;
    int failures = 0;

    bit          busy_m [32];
    bit          held_m;
    logic [31:0] instr_m;
    int          stall_m;
    int          opcodes [7] = '{'h13, 'h33, 'h23, 'h63, 'h37, 'h17, 'h6F};

    function automatic int op_of(input logic [31:0] x);  return int'(x & 32'h7F);         endfunction
    function automatic int rd_of(input logic [31:0] x);  return int'((x >> 7) & 32'h1F);  endfunction
    function automatic int rs1_of(input logic [31:0] x); return int'((x >> 15) & 32'h1F); endfunction
    function automatic int rs2_of(input logic [31:0] x); return int'((x >> 20) & 32'h1F); endfunction

    function automatic bit uses_rs1(input int op); return !(op == 'h37 || op == 'h17 || op == 'h6F); endfunction
    function automatic bit uses_rs2(input int op); return (op == 'h33 || op == 'h23 || op == 'h63);  endfunction
    function automatic bit uses_rd(input int op);  return !(op == 'h23 || op == 'h63);               endfunction

    function automatic bit reg_blocked(input int r);
        bit b;
        b = (r != 0) && busy_m[r];
`ifdef ISSUE_WB_BYPASS_EN
        if (wb_valid && int'(wb_rd) == r) b = 1'b0;
`endif
        return b;
    endfunction

    function automatic bit hazard_m();
        int op;
        op = op_of(instr_m);
        return held_m && ((uses_rs1(op) && reg_blocked(rs1_of(instr_m)))
                       || (uses_rs2(op) && reg_blocked(rs2_of(instr_m)))
                       || (uses_rd(op)  && reg_blocked(rd_of(instr_m))));
    endfunction

    task automatic model_reset();
        foreach (busy_m[r]) busy_m[r] = 1'b0;
        held_m  = 1'b0;
        instr_m = '0;
        stall_m = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit do_chk);
        bit hz, iv, fr, iss, fet;
        int op, rd;
        @(negedge clk);
        hz = hazard_m();
        iv = held_m && !hz && !flush;
        fr = !flush && (!held_m || (iv && i_ready));
        if (do_chk) begin
            chk("i_valid", 32'(i_valid), 32'(iv));
            chk("f_ready", 32'(f_ready), 32'(fr));
            chk("stall_cnt", 32'(stall_cnt), 32'(stall_m));
            if (held_m) begin
                chk("i_instr", i_instr, instr_m);
                chk("i_rs1", 32'(i_rs1), 32'(rs1_of(instr_m)));
                chk("i_rs2", 32'(i_rs2), 32'(rs2_of(instr_m)));
                chk("i_rd", 32'(i_rd), 32'(rd_of(instr_m)));
                chk("i_opcode", 32'(i_opcode), 32'(op_of(instr_m)));
            end
        end
        iss = iv && i_ready;
        fet = f_valid && fr;
        op  = op_of(instr_m);
        rd  = rd_of(instr_m);
        @(posedge clk);
        if (wb_valid && wb_rd != 5'd0) busy_m[wb_rd] = 1'b0;
        if (iss && uses_rd(op) && rd != 0) busy_m[rd] = 1'b1;
        if (hz && stall_m < 65535) stall_m++;
        if (flush) begin
            held_m  = 1'b0;
            instr_m = '0;
        end else if (fet) begin
            held_m  = 1'b1;
            instr_m = f_instr;
        end else if (iss) begin
            held_m  = 1'b0;
        end
        #1;
    endtask

    task automatic go(input bit fv, input logic [31:0] fi, input bit ir,
                      input bit wv, input logic [4:0] wr, input bit fl);
        f_valid  = fv;
        f_instr  = fi;
        i_ready  = ir;
        wb_valid = wv;
        wb_rd    = wr;
        flush    = fl;
        step(1'b1);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom & 32'hFE007000;
        w = w | (32'($urandom_range(0, 7)) << 20) | (32'($urandom_range(0, 7)) << 15)
              | (32'($urandom_range(0, 7)) << 7) | 32'(opcodes[$urandom_range(0, 6)]);
        return w;
    endfunction

    initial begin
        model_reset();
        #12;
        rst_n = 1'b1;
        chk("reset_i_valid", 32'(i_valid), 32'd0);
        chk("reset_f_ready", 32'(f_ready), 32'd1);
        chk("reset_i_instr", i_instr, 32'd0);
        chk("reset_fields", {i_rs1, i_rs2, i_rd, i_opcode}, 32'd0);
        chk("reset_stall", 32'(stall_cnt), 32'd0);

        go(0, '0, 1, 0, 0, 0);
        go(1, ADDI_X1, 1, 0, 0, 0);
        go(1, ADDI_X2, 1, 0, 0, 0);
        go(0, '0, 1, 0, 0, 0);
        chk("b2b_no_stall", 32'(stall_cnt), 32'd0);

        go(1, ADD_321, 1, 0, 0, 0);
        repeat (3) go(0, '0, 1, 0, 0, 0);
        go(0, '0, 1, 1, 5'd2, 0);
        go(0, '0, 1, 1, 5'd1, 0);
        go(0, '0, 1, 0, 0, 0);
        go(0, '0, 1, 0, 0, 0);

        go(1, SW_12, 1, 0, 0, 0);
        go(1, LUI_X0, 1, 0, 0, 0);
        go(1, ADDI_70, 1, 0, 0, 0);
        go(0, '0, 1, 0, 0, 0);

        go(1, ADDI_X5, 1, 0, 0, 0);
        go(1, ADDI_65, 1, 1, 5'd5, 0);
        go(0, '0, 1, 0, 0, 0);
        go(0, '0, 1, 0, 0, 0);
        go(0, '0, 1, 0, 0, 1);
        go(1, ADDI_65, 1, 0, 0, 0);
        go(0, '0, 1, 0, 0, 0);
        go(0, '0, 1, 1, 5'd5, 0);
        go(0, '0, 1, 0, 0, 0);

        for (int n = 0; n < 3000; n++) begin
            go($urandom_range(0, 9) < 7, rand_instr(), $urandom_range(0, 3) != 0,
               $urandom_range(0, 9) < 4, 5'($urandom_range(0, 7)), $urandom_range(0, 99) < 3);
        end

        go(0, '0, 1, 0, 0, 1);
        for (int r = 1; r < 32; r++) go(0, '0, 1, 1, 5'(r), 0);
        go(1, ADDI_X1, 1, 0, 0, 0);
        go(1, ADDI_X2, 1, 0, 0, 0);
        go(1, ADDI_X3, 1, 0, 0, 0);
        go(1, ADD_321, 1, 0, 0, 0);
        repeat (3) go(0, '0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_i_valid", 32'(i_valid), 32'd0);
        chk("async_rst_f_ready", 32'(f_ready), 32'd1);
        chk("async_rst_stall", 32'(stall_cnt), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        go(1, ADD_321, 1, 0, 0, 0);
        go(0, '0, 1, 0, 0, 0);

        go(1, ADD_321, 1, 0, 0, 0);
        f_valid = 1'b0;
        for (int n = 0; n < 70000; n++) step(1'b0);
        go(0, '0, 1, 0, 0, 0);
        chk("stall_saturated", 32'(stall_cnt), 32'h0000FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
